ibex_instr_mem_responder: RTL

Memory-side responder for the core's instruction fetch bus (req/gnt/addr → rvalid/rdata/err). It holds a word-addressed instruction RAM, grants requests subject to an outstanding-request limit and stall injection, and returns data in order with a fixed, parameterised latency. It sits opposite the prefetch buffer in block-level and core-level benches, and serves as a simple on-chip boot/instruction memory in small configurations.

---
 rtl/ibex_instr_mem_responder.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/ibex_instr_mem_responder.sv
// ibex_instr_mem_responder
//
// Memory-side responder for the instruction fetch bus. It holds a word-addressed
// instruction RAM and grants requests up to an outstanding-request limit. Responses
// come back in grant order after a fixed latency.
//
// Parameters:
//   MemWords       RAM depth in 32-bit words (power of two, 16..65536)
//   Latency        cycles from the grant edge to rvalid (1..8)
//   MaxOutstanding max granted-but-unanswered requests (1..8)
//
// Ports:
//   clk_i, rst_i          clock; synchronous active-high reset
//   instr_req_i           request valid
//   instr_addr_i          byte address; bits [1:0] are ignored
//   instr_gnt_o           request accepted this cycle (combinational)
//   instr_rvalid_o        response valid (registered)
//   instr_rdata_o         response data; 0 when there is no response
//   instr_err_o           response error (out-of-range word); 0 when there is no response
//   stall_i               suppresses the grant this cycle
//   mem_we_i/waddr/wdata  backdoor RAM write port, independent of bus traffic
//
// Optional feature: define IBEX_INSTR_RESP_RANDOM_STALL_EN to add LFSR-driven random
// grant stalls. These stalls suppress about 25% of grants.
module ibex_instr_mem_responder #(
  parameter int unsigned MemWords       = 1024,
  parameter int unsigned Latency        = 1,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        instr_req_i,
  output logic                        instr_gnt_o,
  input  logic [31:0]                 instr_addr_i,
  output logic                        instr_rvalid_o,
  output logic [31:0]                 instr_rdata_o,
  output logic                        instr_err_o,
  input  logic                        stall_i,
  input  logic                        mem_we_i,
  input  logic [$clog2(MemWords)-1:0] mem_waddr_i,
  input  logic [31:0]                 mem_wdata_i
);

  localparam int unsigned Aw = $clog2(MemWords);

  logic [31:0] mem_q [MemWords];

  logic [Latency-1:0] vld_q, vld_d;
  logic [Latency-1:0] err_q, err_d;
  logic [31:0]        rdata_q [Latency];
  logic [31:0]        rdata_d [Latency];

  logic [3:0]    outstanding_q, outstanding_d;
  logic          retire;
  logic          stall_rand;
  logic          in_range;
  logic [Aw-1:0] word_idx;
  logic          unused_addr;

  assign unused_addr = ^instr_addr_i[1:0];
  assign word_idx    = instr_addr_i[Aw+1:2];
  assign in_range    = ~|instr_addr_i[31:Aw+2];

`ifdef IBEX_INSTR_RESP_RANDOM_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR, taps 16,14,13,11.
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign stall_rand = (lfsr_q[1:0] == 2'b00);
`else
  assign stall_rand = 1'b0;
`endif

  // A retiring response frees its slot in the same cycle. This allows a grant even
  // when the outstanding count is at its limit.
  assign retire = vld_q[Latency-1];

  always_comb begin
    instr_gnt_o = instr_req_i & ~stall_i & ~stall_rand & ~rst_i &
                  ((outstanding_q < 4'(MaxOutstanding)) | retire);
  end

  always_comb begin
    outstanding_d = outstanding_q;
    unique case ({instr_gnt_o, retire})
      2'b10:   outstanding_d = outstanding_q + 4'd1;
      2'b01:   outstanding_d = outstanding_q - 4'd1;
      default: outstanding_d = outstanding_q;
    endcase
  end

  // Delay line. Empty slots carry zero data, so the outputs are 0 whenever rvalid is low.
  // The RAM is read combinationally here; a same-edge backdoor write lands after this
  // read, so the response carries the old word.
  always_comb begin
    vld_d      = '0;
    err_d      = '0;
    rdata_d[0] = 32'h0;
    if (instr_gnt_o) begin
      vld_d[0]   = 1'b1;
      err_d[0]   = ~in_range;
      rdata_d[0] = in_range ? mem_q[word_idx] : 32'h0;
    end
    for (int i = 1; i < int'(Latency); i++) begin
      vld_d[i]   = vld_q[i-1];
      err_d[i]   = err_q[i-1];
      rdata_d[i] = rdata_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q         <= '0;
      err_q         <= '0;
      outstanding_q <= '0;
      for (int i = 0; i < int'(Latency); i++) begin
        rdata_q[i] <= 32'h0;
      end
    end else begin
      vld_q         <= vld_d;
      err_q         <= err_d;
      outstanding_q <= outstanding_d;
      for (int i = 0; i < int'(Latency); i++) begin
        rdata_q[i] <= rdata_d[i];
      end
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk_i) begin
    if (mem_we_i) begin
      mem_q[mem_waddr_i] <= mem_wdata_i;
    end
  end

  assign instr_rvalid_o = vld_q[Latency-1];
  assign instr_err_o    = err_q[Latency-1];
  assign instr_rdata_o  = rdata_q[Latency-1];

endmodule
